// File: rtl/piezo_sfx_pkg.sv
// Shared definitions for the piezo sound-effect scheduler.
//
// Contents:
//   - Note divider constants for a 50 MHz clock (divider = 50e6 / (2 * f)).
//   - ROM entry field widths and a helper that packs {freq_div, dur}.
//   - Scheduler FSM state type.
package piezo_sfx_pkg;

   localparam int FREQ_W  = 20;
   localparam int DUR_W   = 8;
   localparam int ENTRY_W = FREQ_W + DUR_W;

   localparam logic [FREQ_W-1:0] NOTE_A4 = 20'd56818;
   localparam logic [FREQ_W-1:0] NOTE_C5 = 20'd47778;
   localparam logic [FREQ_W-1:0] NOTE_E5 = 20'd37922;
   localparam logic [FREQ_W-1:0] NOTE_G5 = 20'd31888;
   localparam logic [FREQ_W-1:0] REST    = 20'd0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      PLAY = 2'd2,
      GAP  = 2'd3
   } state_t;

   function automatic logic [ENTRY_W-1:0] make_entry(input logic [FREQ_W-1:0] freq,
                                                     input logic [DUR_W-1:0]  dur);
      return {freq, dur};
   endfunction

endpackage

// File: rtl/sfx_rom.sv
// Sound-effect note ROM (combinational).
//
// Ports:
//   id        in   ID_W     effect index
//   note_idx  in   IDX_W    note slot within the effect
//   entry     out  ENTRY_W  {freq_div[19:0], dur[7:0]}; dur == 0 terminates,
//                           freq_div == 0 is a rest
//
// Contents:
//   sfx0 = {A4 dur 2, end}
//   sfx1 = {C5 dur 1, REST dur 1, C5 dur 1, end}
//   sfx2 = {E5 dur 2, G5 dur 2, end}
//   sfx3 = {G5 dur 1 in all eight slots}  (no terminator: ends on slot count)
module sfx_rom
   import piezo_sfx_pkg::*;
#(
   parameter int ID_W  = 2,
   parameter int IDX_W = 4
) (
   input  logic [ID_W-1:0]    id,
   input  logic [IDX_W-1:0]   note_idx,
   output logic [ENTRY_W-1:0] entry
);

   always_comb begin
      entry = '0;
      case (int'(id))
         0: case (int'(note_idx))
               0:       entry = make_entry(NOTE_A4, 8'd2);
               default: entry = '0;
            endcase
         1: case (int'(note_idx))
               0:       entry = make_entry(NOTE_C5, 8'd1);
               1:       entry = make_entry(REST,    8'd1);
               2:       entry = make_entry(NOTE_C5, 8'd1);
               default: entry = '0;
            endcase
         2: case (int'(note_idx))
               0:       entry = make_entry(NOTE_E5, 8'd2);
               1:       entry = make_entry(NOTE_G5, 8'd2);
               default: entry = '0;
            endcase
         default: begin
            if (int'(note_idx) < 8) entry = make_entry(NOTE_G5, 8'd1);
         end
      endcase
   end

endmodule

// File: rtl/piezo_sfx_scheduler.sv
// Sound-effect scheduler for the piezo driver.
//
// Latches one-cycle play requests, picks the lowest-index pending effect,
// steps its note list out of sfx_rom and drives the driver's enable and
// frequency divider. A request from a lower index preempts the running
// effect; stop aborts everything.
//
// Ports:
//   clk             in   1      system clock
//   rst_n           in   1      asynchronous active-low reset
//   req             in   N_SFX  play request, one-cycle pulse per bit
//   stop            in   1      synchronous abort of everything
//   piezo_en        out  1      driver enable (high only while playing a note)
//   piezo_freq_div  out  20     driver frequency divider (0 when not playing)
//   busy            out  1      scheduler not idle
//   active_id       out  ID_W   selected effect, valid while busy
//   done            out  1      one-cycle pulse on normal completion
module piezo_sfx_scheduler
   import piezo_sfx_pkg::*;
#(
   parameter int N_SFX         = 4,
   parameter int NOTES_PER_SFX = 8,
   parameter int TICK_DIV      = 500000,
   parameter int GAP_TICKS     = 1,
   parameter int ID_W          = $clog2(N_SFX)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_SFX-1:0]  req,
   input  logic              stop,
   output logic              piezo_en,
   output logic [FREQ_W-1:0] piezo_freq_div,
   output logic              busy,
   output logic [ID_W-1:0]   active_id,
   output logic              done
);

   localparam int IDX_W  = $clog2(NOTES_PER_SFX + 1);
   localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [TICK_W-1:0] TICK_MAX  = TICK_W'(TICK_DIV - 1);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NOTES_PER_SFX);
   localparam logic [DUR_W-1:0]  GAP_LOAD  = DUR_W'(GAP_TICKS);

   state_t             state;
   logic [N_SFX-1:0]   pending;
   logic [ID_W-1:0]    id;
   logic [IDX_W-1:0]   note_idx;
   logic [TICK_W-1:0]  tick_cnt;
   logic [DUR_W-1:0]   dur_cnt;   // note ticks in PLAY, gap ticks in GAP
   logic [FREQ_W-1:0]  freq;

   logic [ENTRY_W-1:0] rom_entry;
   logic [FREQ_W-1:0]  rom_freq;
   logic [DUR_W-1:0]   rom_dur;

   logic [ID_W-1:0]    sel_id;
   logic [ID_W-1:0]    pre_id;
   logic               pre_hit;
   logic [N_SFX-1:0]   sel_mask;
   logic [N_SFX-1:0]   pre_mask;
   logic [N_SFX-1:0]   pend_in;
   logic [IDX_W-1:0]   note_next;
   logic               tick_wrap;
   logic               last_tick;

   sfx_rom #(
      .ID_W  (ID_W),
      .IDX_W (IDX_W)
   ) u_rom (
      .id       (id),
      .note_idx (note_idx),
      .entry    (rom_entry)
   );

   assign rom_freq = rom_entry[ENTRY_W-1 -: FREQ_W];
   assign rom_dur  = rom_entry[DUR_W-1:0];

   // Lowest pending bit for a fresh start, lowest req bit below the running
   // id for preemption (descending loops leave the lowest match).
   always_comb begin
      sel_id  = '0;
      pre_id  = '0;
      pre_hit = 1'b0;
      for (int i = N_SFX - 1; i >= 0; i--) begin
         if (pending[i]) sel_id = ID_W'(i);
         if (req[i] && (ID_W'(i) < id)) begin
            pre_hit = 1'b1;
            pre_id  = ID_W'(i);
         end
      end
   end

   assign sel_mask  = N_SFX'(1) << sel_id;
   assign pre_mask  = N_SFX'(1) << pre_id;
   assign pend_in   = pending | req;
   assign note_next = note_idx + IDX_W'(1);
   assign tick_wrap = (tick_cnt == TICK_MAX);
   assign last_tick = tick_wrap && (dur_cnt == DUR_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         pending  <= '0;
         id       <= '0;
         note_idx <= '0;
         tick_cnt <= '0;
         dur_cnt  <= '0;
         freq     <= '0;
         done     <= 1'b0;
      end else begin
         done    <= 1'b0;
         pending <= pend_in;
         if (stop) begin
            state   <= IDLE;
            pending <= '0;
         end else if ((state != IDLE) && pre_hit) begin
            // Aborted effect is dropped; its pending bit is not restored.
            state    <= LOAD;
            id       <= pre_id;
            note_idx <= '0;
            tick_cnt <= '0;
            dur_cnt  <= '0;
            pending  <= pend_in & ~pre_mask;
         end else begin
            case (state)
               IDLE: begin
                  if (|pending) begin
                     state    <= LOAD;
                     id       <= sel_id;
                     note_idx <= '0;
                     pending  <= pend_in & ~sel_mask;
                  end
               end
               LOAD: begin
                  freq <= rom_freq;
                  if (rom_dur == '0) begin
                     done  <= 1'b1;
                     state <= IDLE;
                  end else begin
                     dur_cnt  <= rom_dur;
                     tick_cnt <= '0;
                     state    <= PLAY;
                  end
               end
               PLAY: begin
                  if (tick_wrap) begin
                     tick_cnt <= '0;
                     if (last_tick) begin
                        note_idx <= note_next;
                        if (GAP_TICKS != 0) begin
                           dur_cnt <= GAP_LOAD;
                           state   <= GAP;
                        end else if (note_next == LAST_IDX) begin
                           done  <= 1'b1;
                           state <= IDLE;
                        end else begin
                           state <= LOAD;
                        end
                     end else begin
                        dur_cnt <= dur_cnt - DUR_W'(1);
                     end
                  end else begin
                     tick_cnt <= tick_cnt + TICK_W'(1);
                  end
               end
               GAP: begin
                  if (tick_wrap) begin
                     tick_cnt <= '0;
                     if (last_tick) begin
                        if (note_idx == LAST_IDX) begin
                           done  <= 1'b1;
                           state <= IDLE;
                        end else begin
                           state <= LOAD;
                        end
                     end else begin
                        dur_cnt <= dur_cnt - DUR_W'(1);
                     end
                  end else begin
                     tick_cnt <= tick_cnt + TICK_W'(1);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign piezo_en       = (state == PLAY);
   assign piezo_freq_div = (state == PLAY) ? freq : '0;
   assign busy           = (state != IDLE);
   assign active_id      = id;

endmodule

// File: tb/tb_piezo_sfx_scheduler.sv
// Bench for piezo_sfx_scheduler with TICK_DIV = 4, GAP_TICKS = 1.
// Cycle-by-cycle vector table for single play, rest sequence, queueing and
// the full-slot effect, followed by hand-written preemption, stop and
// asynchronous-reset sequences.
module tb_piezo_sfx_scheduler;

   localparam logic [19:0] F_A4 = 20'd56818;
   localparam logic [19:0] F_C5 = 20'd47778;
   localparam logic [19:0] F_G5 = 20'd31888;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req = '0;
   logic        stop = 1'b0;
   logic        piezo_en;
   logic [19:0] piezo_freq_div;
   logic        busy;
   logic [1:0]  active_id;
   logic        done;

   piezo_sfx_scheduler #(
      .N_SFX         (4),
      .NOTES_PER_SFX (8),
      .TICK_DIV      (4),
      .GAP_TICKS     (1)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req            (req),
      .stop           (stop),
      .piezo_en       (piezo_en),
      .piezo_freq_div (piezo_freq_div),
      .busy           (busy),
      .active_id      (active_id),
      .done           (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  req;
      logic        stop;
      logic        en;
      logic [19:0] freq;
      logic        busy;
      logic        done;
      logic [1:0]  id;
   } vec_t;

   vec_t vec[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic void add(input int n, input logic [3:0] r, input logic en,
                               input logic [19:0] f, input logic b, input logic d,
                               input logic [1:0] id);
      vec_t v;
      v.req = '0; v.stop = 1'b0; v.en = en; v.freq = f; v.busy = b; v.done = d; v.id = id;
      for (int i = 0; i < n; i++) begin
         v.req = (i == 0) ? r : 4'b0000;
         vec.push_back(v);
      end
   endfunction

   // Expected trace from LOAD of note 0 through the done cycle.
   function automatic void add_sfx0();
      add(1, 4'b0, 1'b0, 20'd0, 1'b1, 1'b0, 2'd0);
      add(8, 4'b0, 1'b1, F_A4,  1'b1, 1'b0, 2'd0);
      add(5, 4'b0, 1'b0, 20'd0, 1'b1, 1'b0, 2'd0);
      add(1, 4'b0, 1'b0, 20'd0, 1'b0, 1'b1, 2'd0);
   endfunction

   function automatic void add_sfx1();
      add(1, 4'b0, 1'b0, 20'd0, 1'b1, 1'b0, 2'd1);
      add(4, 4'b0, 1'b1, F_C5,  1'b1, 1'b0, 2'd1);
      add(5, 4'b0, 1'b0, 20'd0, 1'b1, 1'b0, 2'd1);
      add(4, 4'b0, 1'b1, 20'd0, 1'b1, 1'b0, 2'd1);
      add(5, 4'b0, 1'b0, 20'd0, 1'b1, 1'b0, 2'd1);
      add(4, 4'b0, 1'b1, F_C5,  1'b1, 1'b0, 2'd1);
      add(5, 4'b0, 1'b0, 20'd0, 1'b1, 1'b0, 2'd1);
      add(1, 4'b0, 1'b0, 20'd0, 1'b0, 1'b1, 2'd1);
   endfunction

   // Eight one-tick notes, no terminator: the last gap ends straight in done.
   function automatic void add_sfx3();
      add(1, 4'b0, 1'b0, 20'd0, 1'b1, 1'b0, 2'd3);
      for (int n = 0; n < 7; n++) begin
         add(4, 4'b0, 1'b1, F_G5,  1'b1, 1'b0, 2'd3);
         add(5, 4'b0, 1'b0, 20'd0, 1'b1, 1'b0, 2'd3);
      end
      add(4, 4'b0, 1'b1, F_G5,  1'b1, 1'b0, 2'd3);
      add(4, 4'b0, 1'b0, 20'd0, 1'b1, 1'b0, 2'd3);
      add(1, 4'b0, 1'b0, 20'd0, 1'b0, 1'b1, 2'd3);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input logic [3:0] r, input logic s);
      req  = r;
      stop = s;
      @(posedge clk);
      #1;
      req  = '0;
      stop = 1'b0;
   endtask

   int dones;
   int bad;
   logic busy_at_done;

   initial begin
      // Single play of sfx0.
      add(1, 4'b0001, 1'b0, 20'd0, 1'b0, 1'b0, 2'd0);
      add_sfx0();
      add(2, 4'b0, 1'b0, 20'd0, 1'b0, 1'b0, 2'd0);
      // sfx1 with a rest in the middle.
      add(1, 4'b0010, 1'b0, 20'd0, 1'b0, 1'b0, 2'd0);
      add_sfx1();
      add(2, 4'b0, 1'b0, 20'd0, 1'b0, 1'b0, 2'd0);
      // Simultaneous requests: sfx0 then sfx1, two done pulses.
      add(1, 4'b0011, 1'b0, 20'd0, 1'b0, 1'b0, 2'd0);
      add_sfx0();
      add_sfx1();
      add(2, 4'b0, 1'b0, 20'd0, 1'b0, 1'b0, 2'd0);
      // Effect that fills every slot.
      add(1, 4'b1000, 1'b0, 20'd0, 1'b0, 1'b0, 2'd0);
      add_sfx3();
      add(2, 4'b0, 1'b0, 20'd0, 1'b0, 1'b0, 2'd0);

      // Reset state, checked before any clock edge.
      #2;
      chk("reset_en",   piezo_en,       0);
      chk("reset_freq", piezo_freq_div, 0);
      chk("reset_busy", busy,           0);
      chk("reset_done", done,           0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < vec.size(); i++) begin
         step(vec[i].req, vec[i].stop);
         chk($sformatf("vec%0d_en", i),   piezo_en,       vec[i].en);
         chk($sformatf("vec%0d_freq", i), piezo_freq_div, vec[i].freq);
         chk($sformatf("vec%0d_busy", i), busy,           vec[i].busy);
         chk($sformatf("vec%0d_done", i), done,           vec[i].done);
         if (vec[i].busy) chk($sformatf("vec%0d_id", i), active_id, vec[i].id);
      end

      // Preemption: sfx0 requested during sfx1's rest note.
      step(4'b0010, 1'b0);
      dones = 0;
      for (int i = 0; i < 11; i++) begin
         step(4'b0, 1'b0);
         dones += int'(done);
      end
      chk("pre_rest_en",   piezo_en,       1);
      chk("pre_rest_freq", piezo_freq_div, 0);
      step(4'b0001, 1'b0);
      dones += int'(done);
      chk("pre_load_en",   piezo_en,  0);
      chk("pre_load_busy", busy,      1);
      chk("pre_load_id",   active_id, 0);
      step(4'b0, 1'b0);
      chk("pre_play_en",   piezo_en,       1);
      chk("pre_play_freq", piezo_freq_div, F_A4);
      busy_at_done = 1'b1;
      for (int i = 0; i < 30; i++) begin
         step(4'b0, 1'b0);
         if (done) begin
            dones++;
            busy_at_done = busy;
         end
      end
      chk("pre_done_count", dones, 1);
      chk("pre_done_busy",  busy_at_done, 0);
      chk("pre_no_replay",  busy, 0);

      // stop together with a request during PLAY.
      step(4'b0010, 1'b0);
      step(4'b0, 1'b0);
      step(4'b0, 1'b0);
      chk("stop_play_en", piezo_en, 1);
      step(4'b0100, 1'b1);
      chk("stop_en",   piezo_en, 0);
      chk("stop_busy", busy,     0);
      chk("stop_done", done,     0);
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         step(4'b0, 1'b0);
         if (busy || done || piezo_en) bad++;
      end
      chk("stop_quiet", bad, 0);

      // Asynchronous reset in the middle of sfx1's rest note.
      step(4'b0010, 1'b0);
      for (int i = 0; i < 11; i++) step(4'b0, 1'b0);
      chk("rst_pre_en",   piezo_en,       1);
      chk("rst_pre_busy", busy,           1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_en",   piezo_en,       0);
      chk("rst_async_freq", piezo_freq_div, 0);
      chk("rst_async_busy", busy,           0);
      chk("rst_async_done", done,           0);
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_hold_busy", busy, 0);
      rst_n = 1'b1;
      step(4'b0010, 1'b0);
      step(4'b0, 1'b0);
      chk("rst_restart_load", busy, 1);
      step(4'b0, 1'b0);
      chk("rst_restart_en",   piezo_en,       1);
      chk("rst_restart_freq", piezo_freq_div, F_C5);
      chk("rst_restart_id",   active_id,      1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
